// File: rtl/count_seq_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_pkg
// Shared types and default sizes for the count sequencer and its counter core.
//   seq_state_t : run-controller state encoding (IDLE, RUN, DONE)
//   W_DEF       : default counter width
//   RW_DEF      : default pass-count width
// ---------------------------------------------------------------------------
package count_seq_pkg;

  localparam int unsigned W_DEF  = 4;
  localparam int unsigned RW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/count_core.sv
// ---------------------------------------------------------------------------
// count_core
// W-bit up/down counter register with load and enable. Load has priority over
// enable; counting wraps modulo 2^W in both directions.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-high (count -> 0)
//   load     in   load load_val this cycle
//   load_val in   W  value to load
//   en       in   step the counter this cycle
//   up       in   step direction, 1 = increment, 0 = decrement
//   count    out  W  current counter value
// ---------------------------------------------------------------------------
module count_core
  import count_seq_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // NOTE: state registers are written with <= only, so every always_ff reads
  // the pre-edge value of every other register regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      // Natural W-bit overflow provides the 15->0 / 0->15 wrap.
      r_count <= up ? r_count + 1'b1 : r_count - 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
// Run controller for a W-bit up/down counter. On an accepted start it captures
// direction, start, terminal and pass count, then steps the counter from start
// to terminal once per pass, reloading between passes. Reports a pulse per
// completed pass and a pulse when the whole run completes. Supports hold
// (freeze while running) and abort (return to IDLE at once, no done).
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   start      in   run request, taken only when ready and not abort
//   ready      out  high in IDLE
//   cfg_up     in   direction, 1 = up, 0 = down
//   cfg_start  in   W  start/reload value
//   cfg_end    in   W  terminal value
//   cfg_passes in   RW number of passes, 0 = run until abort
//   hold       in   freeze counting while in RUN
//   abort      in   terminate the run
//   count      out  W  current counter value
//   busy       out  state != IDLE
//   pass_done  out  pulse: terminal reached this cycle (RUN, not held)
//   pass_cnt   out  RW completed passes in current run
//   done       out  pulse: run completed normally (DONE state)
// ---------------------------------------------------------------------------
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ready,
  input  logic          cfg_up,
  input  logic [W-1:0]  cfg_start,
  input  logic [W-1:0]  cfg_end,
  input  logic [RW-1:0] cfg_passes,
  input  logic          hold,
  input  logic          abort,
  output logic [W-1:0]  count,
  output logic          busy,
  output logic          pass_done,
  output logic [RW-1:0] pass_cnt,
  output logic          done
);

  seq_state_t    r_state;
  logic          r_up;
  logic [W-1:0]  r_start;
  logic [W-1:0]  r_end;
  logic [RW-1:0] r_passes;
  logic [RW-1:0] r_pass_cnt;

  logic          w_in_run;
  logic          w_accept;
  logic          w_terminal;
  logic          w_advance;
  logic          w_last;
  logic [RW-1:0] w_pass_inc;
  logic          w_load;
  logic [W-1:0]  w_load_val;
  logic          w_en;
  logic [W-1:0]  w_count;

  assign w_in_run   = (r_state == RUN);
  assign w_accept   = (r_state == IDLE) && start && !abort;
  assign w_terminal = w_in_run && (w_count == r_end);
  // A terminal cycle only counts as a completed pass when neither abort nor
  // hold overrides it.
  assign w_advance  = w_terminal && !abort && !hold;
  assign w_pass_inc = r_pass_cnt + 1'b1;
  assign w_last     = (r_passes != '0) && (w_pass_inc == r_passes);

  // Reload on a non-final pass end; the final pass leaves count on terminal.
  assign w_load     = w_accept || (w_advance && !w_last);
  assign w_load_val = w_accept ? cfg_start : r_start;
  assign w_en       = w_in_run && !hold && !w_terminal && !abort;

  count_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .up       (r_up),
    .count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pass_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= RUN;
            r_pass_cnt <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (w_advance) begin
            r_pass_cnt <= w_pass_inc;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: configuration registers are deliberately left out of reset; they
  // are only consulted in RUN, which can only be entered through a capture.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_up     <= cfg_up;
      r_start  <= cfg_start;
      r_end    <= cfg_end;
      r_passes <= cfg_passes;
    end
  end

  assign ready     = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign pass_done = w_terminal && !hold;
  assign count     = w_count;
  assign pass_cnt  = r_pass_cnt;

endmodule

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
// Scoreboard bench: the stimulus process drives inputs for each cycle and
// queues the outputs expected in that cycle; a monitor on the falling edge
// pops and compares every queued entry.
// ---------------------------------------------------------------------------
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ready;
  logic       cfg_up;
  logic [3:0] cfg_start;
  logic [3:0] cfg_end;
  logic [3:0] cfg_passes;
  logic       hold;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       pass_done;
  logic [3:0] pass_cnt;
  logic       done;

  always #5 clk = ~clk;

  count_sequencer #(.W(4), .RW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready      (ready),
    .cfg_up     (cfg_up),
    .cfg_start  (cfg_start),
    .cfg_end    (cfg_end),
    .cfg_passes (cfg_passes),
    .hold       (hold),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .pass_done  (pass_done),
    .pass_cnt   (pass_cnt),
    .done       (done)
  );

  typedef struct {
    int         cyc;
    logic       rdy;
    logic       bsy;
    logic       dn;
    logic       pd;
    logic [3:0] cnt;
    logic [3:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares whatever the stimulus side queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("c%0d.ready", e.cyc),     {7'd0, ready},     {7'd0, e.rdy});
        check($sformatf("c%0d.busy", e.cyc),      {7'd0, busy},      {7'd0, e.bsy});
        check($sformatf("c%0d.done", e.cyc),      {7'd0, done},      {7'd0, e.dn});
        check($sformatf("c%0d.pass_done", e.cyc), {7'd0, pass_done}, {7'd0, e.pd});
        check($sformatf("c%0d.count", e.cyc),     {4'd0, count},     {4'd0, e.cnt});
        check($sformatf("c%0d.pass_cnt", e.cyc),  {4'd0, pass_cnt},  {4'd0, e.pc});
      end
    end
  end

  // Queue expectations for the current cycle (inputs already applied), then
  // advance to just after the next rising edge.
  task automatic step(input logic rdy, input logic bsy, input logic dn, input logic pd,
                      input logic [3:0] cnt, input logic [3:0] pc);
    exp_t e;
    e.cyc = cyc; e.rdy = rdy; e.bsy = bsy; e.dn = dn; e.pd = pd; e.cnt = cnt; e.pc = pc;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg(input logic up, input logic [3:0] s, input logic [3:0] e, input logic [3:0] p);
    cfg_up = up; cfg_start = s; cfg_end = e; cfg_passes = p;
  endtask

  // Shorthands: rdy/bsy/dn/pd/cnt/pc
  task automatic idle_exp(input logic [3:0] cnt, input logic [3:0] pc);
    step(1'b1, 1'b0, 1'b0, 1'b0, cnt, pc);
  endtask
  task automatic run_exp(input logic pd, input logic [3:0] cnt, input logic [3:0] pc);
    step(1'b0, 1'b1, 1'b0, pd, cnt, pc);
  endtask
  task automatic done_exp(input logic [3:0] cnt, input logic [3:0] pc);
    step(1'b0, 1'b1, 1'b1, 1'b0, cnt, pc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
    cfg(1'b0, 4'd0, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_exp(4'd0, 4'd0);                     // reset values

    // Up, single pass 3..6
    start = 1'b1; cfg(1'b1, 4'd3, 4'd6, 4'd1);
    idle_exp(4'd0, 4'd0);                     // c0: accept
    start = 1'b0;
    run_exp(1'b0, 4'd3, 4'd0);
    run_exp(1'b0, 4'd4, 4'd0);
    run_exp(1'b0, 4'd5, 4'd0);
    run_exp(1'b1, 4'd6, 4'd0);
    done_exp(4'd6, 4'd1);
    idle_exp(4'd6, 4'd1);

    // Down with wrap 1,0,15,14
    start = 1'b1; cfg(1'b0, 4'd1, 4'd14, 4'd1);
    idle_exp(4'd6, 4'd1);
    start = 1'b0;
    run_exp(1'b0, 4'd1, 4'd0);
    run_exp(1'b0, 4'd0, 4'd0);
    run_exp(1'b0, 4'd15, 4'd0);
    run_exp(1'b1, 4'd14, 4'd0);
    done_exp(4'd14, 4'd1);
    idle_exp(4'd14, 4'd1);

    // Multi-pass, start == end == 5, 3 passes
    start = 1'b1; cfg(1'b1, 4'd5, 4'd5, 4'd3);
    idle_exp(4'd14, 4'd1);
    start = 1'b0;
    run_exp(1'b1, 4'd5, 4'd0);
    run_exp(1'b1, 4'd5, 4'd1);
    run_exp(1'b1, 4'd5, 4'd2);
    done_exp(4'd5, 4'd3);
    idle_exp(4'd5, 4'd3);

    // Continuous up 0..15, abort in the 40th RUN cycle
    start = 1'b1; cfg(1'b1, 4'd0, 4'd15, 4'd0);
    idle_exp(4'd5, 4'd3);
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 40) abort = 1'b1;
      run_exp(((i - 1) % 16) == 15, 4'((i - 1) % 16), 4'((i - 1) / 16));
    end
    abort = 1'b0;
    idle_exp(4'd7, 4'd2);                     // IDLE, count held, no done
    idle_exp(4'd7, 4'd2);

    // Hold at terminal; start and cfg changes during RUN ignored
    start = 1'b1; cfg(1'b1, 4'd2, 4'd4, 4'd1);
    idle_exp(4'd7, 4'd2);
    cfg(1'b0, 4'd9, 4'd9, 4'd5);              // start stays high: must be ignored
    run_exp(1'b0, 4'd2, 4'd0);
    run_exp(1'b0, 4'd3, 4'd0);
    hold = 1'b1;
    run_exp(1'b0, 4'd4, 4'd0);
    run_exp(1'b0, 4'd4, 4'd0);
    run_exp(1'b0, 4'd4, 4'd0);
    hold = 1'b0; start = 1'b0;
    run_exp(1'b1, 4'd4, 4'd0);
    done_exp(4'd4, 4'd1);
    idle_exp(4'd4, 4'd1);

    // Reset mid-RUN
    start = 1'b1; cfg(1'b1, 4'd0, 4'd15, 4'd0);
    idle_exp(4'd4, 4'd1);
    start = 1'b0;
    run_exp(1'b0, 4'd0, 4'd0);
    run_exp(1'b0, 4'd1, 4'd0);
    rst = 1'b1;
    run_exp(1'b0, 4'd2, 4'd0);
    rst = 1'b0;
    idle_exp(4'd0, 4'd0);

    // Reset coincident with start: reset wins
    rst = 1'b1; start = 1'b1; cfg(1'b1, 4'd9, 4'd11, 4'd1);
    idle_exp(4'd0, 4'd0);
    rst = 1'b0; start = 1'b0;
    idle_exp(4'd0, 4'd0);

    // Abort coincident with start in IDLE: not accepted
    start = 1'b1; abort = 1'b1;
    idle_exp(4'd0, 4'd0);
    start = 1'b0; abort = 1'b0;
    idle_exp(4'd0, 4'd0);

    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Programmable run controller for a W-bit up/down counter. It accepts a start request with a captured configuration: direction, start value, terminal value and pass count. It then steps the counter from start to terminal once per pass, reloading between passes, and reports per-pass and completion events. It sits between a control/register interface and the counting datapath. It provides hold and abort so software or an upstream FSM can sequence count runs without cycle-level management.

## Interface
- `W`, 4, counter width
- `RW`, 4, pass-count width
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  run request; accepted only when `ready`=1 and `abort`=0
- `ready`  out  1  high in IDLE
- `cfg_up`  in  1  direction, 1 = count up, 0 = count down
- `cfg_start`  in  W  start/reload value
- `cfg_end`  in  W  terminal value
- `cfg_passes`  in  RW  number of passes; 0 = continuous until abort
- `hold`  in  1  freeze counting while in RUN
- `abort`  in  1  terminate run, return to IDLE
- `count`  out  W  current counter value
- `busy`  out  1  state != IDLE
- `pass_done`  out  1  one-cycle pulse, terminal reached
- `pass_cnt`  out  RW  completed passes in current run
- `done`  out  1  one-cycle pulse, run completed normally

## Operation
- States: IDLE, RUN, DONE.
- Reset (`rst`=1 at an edge, any state) forces the following values next cycle:
  - state IDLE, `count`=0, `pass_cnt`=0
  - `ready`=1, `busy`=0, `done`=0, `pass_done`=0
- IDLE with `start`=1 and `abort`=0:
  - capture `cfg_*` into internal registers; `count`<=`cfg_start`; `pass_cnt`<=0; go to RUN.
  - `cfg_*` changes after acceptance have no effect.
- `start` in RUN or DONE is ignored.
- RUN priority: abort > hold > terminal > step.
  - `abort`=1: go to IDLE; `count` and `pass_cnt` hold; no `done`.
  - `hold`=1: no change; `pass_done`=0.
  - `count`==end_reg (terminal):
    - `pass_done`=1 (combinational decode, same cycle).
    - If passes_reg!=0 and `pass_cnt`+1==passes_reg: `pass_cnt`++, `count` holds, go to DONE.
    - Else: `pass_cnt`++ (mod 2^RW), `count`<=start_reg.
  - Otherwise: `count`<=`count`±1, modulo 2^W (wrap 15→0 up, 0→15 down for W=4).
- DONE: `done`=1 for exactly one cycle, then IDLE. `abort` in DONE goes to IDLE with `done` still asserted that cycle.
- Pass length is (end−start) mod 2^W + 1 RUN cycles going up, and (start−end) mod 2^W + 1 going down. When start==end, each pass takes 1 cycle.

## Timing
- `start` accepted at cycle n: RUN and `count`=cfg_start at n+1; first step at n+2.
- Terminal observed at cycle t: DONE at t+1, `ready`=1 at t+2. Minimum run is 3 cycles from acceptance to `ready`.
- `ready`, `busy`, `done` are decodes of the state register. `pass_done` is a decode of state, count, end_reg and `hold`. No input-to-output combinational path except `hold`→`pass_done`.
- Abort latency: 1 cycle to IDLE.
- `rst` coincident with `start` or `abort`: reset wins.

## Structure
- Package `count_seq_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t`
  - default localparams for W and RW
- Sub-module `count_core`: W-bit register with synchronous active-high reset, load, enable and direction. The sequencer drives load (on accept/reload), enable (RUN & !hold & !terminal & !abort) and direction (dir_reg).
- The FSM, config registers and pass counter live in `count_sequencer`.

## Test plan
- Up single pass, start=3, end=6, passes=1, `start` at c0:
  - `count` 3,4,5,6 at c1–c4; `pass_done` at c4; `done` at c5; `ready` at c6; `count` stays 6.
- Down with wrap, up=0, start=1, end=14, passes=1:
  - `count` 1,0,15,14; one `pass_done`, then `done`.
- Multi-pass with start=end=5, passes=3:
  - `pass_done` on 3 consecutive cycles; `pass_cnt` 0,1,2 then 3; `done` once; `count` constant 5.
- Continuous, passes=0, up, start=0, end=15, run 40 cycles then `abort`:
  - `pass_done` every 16 cycles; `pass_cnt`=2 at abort; IDLE next cycle; no `done`; `count` held.
- Hold and ignore, with `hold` high 3 cycles while `count`==end:
  - `count` frozen and `pass_done` low until release.
  - `start` and `cfg_*` changes during RUN have no effect.
- Reset mid-RUN, and `rst` together with `start`:
  - all outputs at reset values next cycle; `ready`=1.
